// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART TX register port among
//               NREQ byte producers. Optional poll timeout: UART_ARB_TIMEOUT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TX_ADDR     = 24,
    parameter int STATUS_ADDR = 28,
    parameter int TX_BUSY_BIT = 0,
    parameter int POLL_LIMIT  = 255
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [31:0]             bus_addr,
    output logic                    bus_ren,
    output logic                    bus_wen,
    output logic [31:0]             bus_wdata,
    input  logic [31:0]             bus_rdata,
    input  logic                    bus_stall,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] last_grant,
    output logic                    err_timeout
);

    localparam int          c_gw     = $clog2(NREQ);
    localparam logic [31:0] c_tx     = 32'(TX_ADDR);
    localparam logic [31:0] c_status = 32'(STATUS_ADDR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POLL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t             r_state, w_state_n;
    logic [NREQ-1:0]    r_req_ready, w_ready_n;
    logic [31:0]        r_addr, w_addr_n;
    logic               r_ren, w_ren_n;
    logic               r_wen, w_wen_n;
    logic [31:0]        r_wdata, w_wdata_n;
    logic               r_busy;
    logic [c_gw-1:0]    r_last_grant, w_grant_n;
    logic [7:0]         r_byte, w_byte_n;
    logic               w_found;
    logic [c_gw-1:0]    w_gidx;
    logic               w_unused_rdata;

    // Only the busy bit of the status word matters.
    assign w_unused_rdata = ^bus_rdata;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_cw = $clog2(POLL_LIMIT + 1);
    logic [c_cw-1:0] r_poll_cnt, w_cnt_n;
    logic            r_err, w_err_n;

    always_ff @(posedge clk or posedge nReset) begin
        if (nReset) begin
            r_poll_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_poll_cnt <= w_cnt_n;
            r_err      <= w_err_n;
        end
    end

    assign err_timeout = r_err;
`else
    localparam int c_unused_poll_limit = POLL_LIMIT;
    assign err_timeout = 1'b0;
`endif

    // Search upward from the slot after the last winner, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_last_grant) + k) % NREQ]) begin
                w_found = 1'b1;
                w_gidx  = c_gw'((int'(r_last_grant) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ready_n = '0;
        w_addr_n  = '0;
        w_ren_n   = 1'b0;
        w_wen_n   = 1'b0;
        w_wdata_n = '0;
        w_grant_n = r_last_grant;
        w_byte_n  = r_byte;
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt_n   = r_poll_cnt;
        w_err_n   = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ready_n = {{(NREQ-1){1'b0}}, 1'b1} << w_gidx;
                    w_byte_n  = req_data[int'(w_gidx)*8 +: 8];
                    w_grant_n = w_gidx;
                    w_state_n = S_POLL;
                    w_ren_n   = 1'b1;
                    w_addr_n  = c_status;
`ifdef UART_ARB_TIMEOUT_EN
                    w_cnt_n   = '0;
`endif
                end
            end
            S_POLL: begin
                w_ren_n  = 1'b1;
                w_addr_n = c_status;
                if (!bus_stall && !bus_rdata[TX_BUSY_BIT]) begin
                    w_state_n = S_WRITE;
                    w_ren_n   = 1'b0;
                    w_wen_n   = 1'b1;
                    w_addr_n  = c_tx;
                    w_wdata_n = {24'b0, r_byte};
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (!bus_stall) begin
                    w_cnt_n = r_poll_cnt + 1'b1;
                    if (int'(r_poll_cnt) + 1 >= POLL_LIMIT) begin
                        w_state_n = S_IDLE;
                        w_ren_n   = 1'b0;
                        w_addr_n  = '0;
                        w_byte_n  = '0;
                        w_err_n   = 1'b1;
                    end
                end
`endif
            end
            S_WRITE: begin
                if (bus_stall) begin
                    w_wen_n   = 1'b1;
                    w_addr_n  = c_tx;
                    w_wdata_n = {24'b0, r_byte};
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nReset) begin
        if (nReset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= '0;
            r_addr       <= '0;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_last_grant <= c_gw'(NREQ - 1);
            r_byte       <= '0;
        end else begin
            r_state      <= w_state_n;
            r_req_ready  <= w_ready_n;
            r_addr       <= w_addr_n;
            r_ren        <= w_ren_n;
            r_wen        <= w_wen_n;
            r_wdata      <= w_wdata_n;
            r_busy       <= (w_state_n != S_IDLE);
            r_last_grant <= w_grant_n;
            r_byte       <= w_byte_n;
        end
    end

    assign req_ready  = r_req_ready;
    assign bus_addr   = r_addr;
    assign bus_ren    = r_ren;
    assign bus_wen    = r_wen;
    assign bus_wdata  = r_wdata;
    assign busy       = r_busy;
    assign last_grant = r_last_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed plus randomized bench for uart_tx_arbiter with
//               producer queues, a status-register model and a bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              nReset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [31:0]       bus_addr;
    logic              bus_ren;
    logic              bus_wen;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_stall;
    logic              busy;
    logic [1:0]        last_grant;
    logic              err_timeout;

    int tests = 0;
    int fails = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .TX_ADDR(24), .STATUS_ADDR(28),
                      .TX_BUSY_BIT(0), .POLL_LIMIT(4)) dut (
        .clk(clk), .nReset(nReset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .bus_addr(bus_addr), .bus_ren(bus_ren),
        .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_stall(bus_stall), .busy(busy), .last_grant(last_grant),
        .err_timeout(err_timeout));

    always #5 clk = ~clk;

    // Producers: each holds valid while its byte queue is non-empty.
    logic [7:0] pmem [NREQ][64];
    int head [NREQ] = '{0, 0, 0, 0};
    int tail [NREQ] = '{0, 0, 0, 0};

    always @(posedge clk)
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) head[i] <= head[i] + 1;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = head[i] < tail[i];
            req_data[i*8 +: 8] = pmem[i][head[i] % 64];
        end
    end

    // UART status model: transaction n reports busy for busy_tab[n] polls.
    int busy_tab [256];
    int polls_done = 0;
    int wr_count   = 0;
    assign bus_rdata = {31'b0, (polls_done < busy_tab[wr_count % 256])};

    always @(posedge clk or posedge nReset) begin
        if (nReset) polls_done <= 0;
        else if (bus_wen && !bus_stall) begin
            polls_done <= 0;
            wr_count   <= wr_count + 1;
        end else if (bus_ren && !bus_stall) polls_done <= polls_done + 1;
    end

    logic stall_force = 1'b0;
    logic stall_rand  = 1'b0;
    bit   rand_stall_en = 1'b0;
    always @(posedge clk) stall_rand <= rand_stall_en && ($urandom_range(0, 3) == 0);
    assign bus_stall = stall_force | stall_rand;

    // Bus monitor
    int         reads = 0;
    logic [7:0] wr_q [$];
    int         acc_q [$];
    int         overlap_cnt = 0, bad_cnt = 0, onehot_bad = 0, nofree_cnt = 0;
    bit         saw_free = 1'b0;

    always @(negedge clk) begin
        if (bus_ren && bus_wen) overlap_cnt++;
        if (bus_ren && !bus_stall) begin
            reads++;
            if (bus_addr != 32'd28) bad_cnt++;
            if (!bus_rdata[0]) saw_free = 1'b1;
        end
        if (bus_wen && !bus_stall) begin
            if (bus_addr != 32'd24 || bus_wdata[31:8] != 24'd0) bad_cnt++;
            if (!saw_free) nofree_cnt++;
            saw_free = 1'b0;
            wr_q.push_back(bus_wdata[7:0]);
        end
        if (req_ready != '0) begin
            if ($countones(req_ready) != 1) onehot_bad++;
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) acc_q.push_back(i);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nReset = 1'b1;
        tick();
        tick();
        nReset = 1'b0;
    endtask

    task automatic push(input int i, input logic [7:0] b);
        pmem[i][tail[i] % 64] = b;
        tail[i] = tail[i] + 1;
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int c = 0;
        while ((wr_q.size() < target || busy) && c < budget) begin
            tick();
            c++;
        end
        check(tag, wr_q.size(), target);
        check({tag, "_idle"}, busy, 0);
    endtask

    // Round-robin reference data for randomized rounds
    logic [7:0] rbytes [NREQ][8];
    int         rn [NREQ];
    int         rem [NREQ];
    int         exp_idx [$];
    logic [7:0] exp_byte [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, abase, r0, w0, ptr, total, exp_reads;
        nReset = 1'b1;
        for (int i = 0; i < 256; i++) busy_tab[i] = 0;
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_ren", bus_ren, 0);
        check("rst_wen", bus_wen, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_timeout, 0);
        check("rst_last_grant", last_grant, 3);
        nReset = 1'b0;

        // Single byte, minimum latency
        push(0, 8'h0F);
        tick();
        check("t1_ready", req_ready, 4'b0001);
        check("t1_ren", bus_ren, 1);
        check("t1_raddr", bus_addr, 28);
        check("t1_busy", busy, 1);
        check("t1_grant", last_grant, 0);
        tick();
        check("t1_wen", bus_wen, 1);
        check("t1_ren_off", bus_ren, 0);
        check("t1_waddr", bus_addr, 24);
        check("t1_wdata", bus_wdata, 32'h0000000F);
        check("t1_ready_off", req_ready, 0);
        tick();
        check("t1_wen_off", bus_wen, 0);
        check("t1_idle", busy, 0);

        // All four requesters contending
        do_reset();
        base  = wr_q.size();
        abase = acc_q.size();
        push(0, 8'hA0); push(0, 8'hA0);
        push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3);
        wait_writes(base + 5, 100, "t2_done");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_acc%0d", k), acc_q[abase + k], k % 4);
            check($sformatf("t2_byte%0d", k), wr_q[base + k], 8'hA0 + 8'(k % 4));
        end
        check("t2_last_grant", last_grant, 0);

        // Transmitter busy for five polls
        r0 = reads;
        base = wr_q.size();
        busy_tab[wr_count % 256] = 5;
        push(1, 8'h33);
        wait_writes(base + 1, 100, "t3_done");
        check("t3_reads", reads - r0, 6);
        check("t3_byte", wr_q[base], 8'h33);

        // Stall held over the write
        push(2, 8'h5A);
        tick();
        tick();
        check("t4_wen0", bus_wen, 1);
        stall_force = 1'b1;
        w0 = wr_q.size();
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t4_wen_hold%0d", k), bus_wen, 1);
            check($sformatf("t4_addr_hold%0d", k), bus_addr, 24);
            check($sformatf("t4_wdata_hold%0d", k), bus_wdata, 32'h5A);
        end
        stall_force = 1'b0;
        tick();
        check("t4_wen_off", bus_wen, 0);
        check("t4_writes", wr_q.size() - w0, 1);
        check("t4_byte", wr_q[w0], 8'h5A);

        // Reset pulse while polling
        busy_tab[wr_count % 256] = 1000;
        push(3, 8'h77);
        tick();
        tick();
        check("t5_polling", bus_ren, 1);
        #2;
        nReset = 1'b1;
        #1;
        check("t5_rst_ren", bus_ren, 0);
        check("t5_rst_addr", bus_addr, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_grant", last_grant, 3);
        busy_tab[wr_count % 256] = 0;
        base = wr_q.size();
        push(0, 8'h11);
        push(3, 8'h78);
        nReset = 1'b0;
        tick();
        check("t5_ready", req_ready, 4'b0001);
        check("t5_grant", last_grant, 0);
        wait_writes(base + 2, 100, "t5_done");
        check("t5_byte0", wr_q[base], 8'h11);
        check("t5_byte1", wr_q[base + 1], 8'h78);

        // Transmitter never frees
        busy_tab[wr_count % 256] = 1000;
        r0 = reads;
        w0 = wr_q.size();
        push(1, 8'h99);
        tick();
        for (int k = 0; k < 4; k++) tick();
`ifdef UART_ARB_TIMEOUT_EN
        check("t6_err", err_timeout, 1);
        check("t6_idle", busy, 0);
        check("t6_ren", bus_ren, 0);
        check("t6_reads", reads - r0, 4);
        tick();
        check("t6_err_sticky", err_timeout, 1);
        check("t6_no_wen", bus_wen, 0);
`else
        check("t6_err", err_timeout, 0);
        check("t6_busy", busy, 1);
        check("t6_ren", bus_ren, 1);
        check("t6_raddr", bus_addr, 28);
`endif
        check("t6_no_write", wr_q.size() - w0, 0);
        busy_tab[wr_count % 256] = 0;
        do_reset();

        // Randomized rounds against a round-robin reference
        for (int round = 0; round < 3; round++) begin
            do_reset();
            base  = wr_q.size();
            abase = acc_q.size();
            r0    = reads;
            total = 0;
            for (int i = 0; i < NREQ; i++) begin
                rn[i]  = (i == 0) ? $urandom_range(1, 5) : $urandom_range(0, 5);
                rem[i] = rn[i];
                total += rn[i];
                for (int j = 0; j < rn[i]; j++) begin
                    rbytes[i][j] = 8'($urandom);
                    push(i, rbytes[i][j]);
                end
            end
            exp_reads = total;
            for (int t = 0; t < total; t++) begin
                busy_tab[(wr_count + t) % 256] = $urandom_range(0, 2);
                exp_reads += busy_tab[(wr_count + t) % 256];
            end
            exp_idx.delete();
            exp_byte.delete();
            ptr = NREQ - 1;
            while (exp_idx.size() < total) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (ptr + k) % NREQ;
                    if (rem[idx] > 0) begin
                        exp_idx.push_back(idx);
                        exp_byte.push_back(rbytes[idx][rn[idx] - rem[idx]]);
                        rem[idx]--;
                        ptr = idx;
                        break;
                    end
                end
            end
            rand_stall_en = 1'b1;
            wait_writes(base + total, total * 40 + 20, $sformatf("r%0d_done", round));
            rand_stall_en = 1'b0;
            for (int k = 0; k < total; k++) begin
                check($sformatf("r%0d_acc%0d", round, k), acc_q[abase + k], exp_idx[k]);
                check($sformatf("r%0d_byte%0d", round, k), wr_q[base + k], exp_byte[k]);
            end
            check($sformatf("r%0d_reads", round), reads - r0, exp_reads);
            check($sformatf("r%0d_last_grant", round), last_grant, exp_idx[total - 1]);
            tick();
        end

        check("no_ren_wen_overlap", overlap_cnt, 0);
        check("bus_addr_data_ok", bad_cnt, 0);
        check("ready_onehot", onehot_bad, 0);
        check("no_write_while_busy", nofree_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path between NREQ on-chip byte producers.
- Bus master on the UART peripheral's bus_protocol register port; sits between the producers and the UART.
- Picks a producer round-robin and latches its byte.
- Polls the UART status register until the transmitter is free, then writes the byte to the UART TX data register.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TX_ADDR, 24, byte address of the UART TX data register.
- STATUS_ADDR, 28, byte address of the UART status register.
- TX_BUSY_BIT, 0, bit of the status read data that is 1 while the transmitter is busy.
- POLL_LIMIT, 255, maximum status polls before timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- nReset  in  1  asynchronous, active-high reset (1 = in reset).
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- bus_addr  out  32  bus address.
- bus_ren  out  1  bus read strobe.
- bus_wen  out  1  bus write strobe.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data; valid in the same cycle as bus_ren when bus_stall=0.
- bus_stall  in  1  peripheral stall; the current access is held while 1.
- busy  out  1  1 whenever the state is not IDLE.
- last_grant  out  $clog2(NREQ)  index of the most recently accepted requester.
- err_timeout  out  1  sticky timeout flag (optional feature).

Behaviour:
- Reset values: req_ready=0, bus_addr=0, bus_ren=0, bus_wen=0, bus_wdata=0, busy=0, err_timeout=0, last_grant=NREQ-1. With last_grant at NREQ-1, requester 0 has first priority after reset.
- Reset asserted mid-operation aborts immediately. The latched byte is discarded, and any bus strobe drops asynchronously.
- All outputs are registered.
- States: IDLE, POLL, WRITE.
- IDLE:
  - If any req_valid is 1, grant the first valid index searching upward from last_grant+1, wrapping modulo NREQ.
  - In that cycle: req_ready[g]=1 for exactly one cycle, latch req_data[g], set last_grant=g, go to POLL.
  - Requesters are not granted again until the FSM returns to IDLE.
- POLL:
  - Drive bus_ren=1 and bus_addr=STATUS_ADDR.
  - bus_stall=1: hold all outputs and stay in POLL.
  - bus_stall=0 and bus_rdata[TX_BUSY_BIT]=1: stay in POLL and poll again next cycle.
  - bus_stall=0 and bus_rdata[TX_BUSY_BIT]=0: next state is WRITE, with bus_ren=0.
- WRITE:
  - Drive bus_wen=1, bus_addr=TX_ADDR, bus_wdata={24'b0, byte}.
  - Hold while bus_stall=1.
  - On the first cycle with bus_stall=0, go to IDLE and drop bus_wen next cycle.
- bus_ren and bus_wen are never 1 in the same cycle.
- Minimum latency with no stalls and UART idle:
  - Accept cycle: IDLE.
  - +1 cycle: POLL.
  - +2 cycles: WRITE.
  - Back in IDLE at +3; next accept at +3. Sustained throughput is therefore one byte per 3 cycles.
- Simultaneous req_valid from several requesters: round-robin order only. A requester that drops req_valid before being accepted loses its slot without error.
- Requester data is sampled only in the accept cycle; later changes have no effect.
- Wrap-around: the search after last_grant=NREQ-1 starts at index 0.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A poll counter clears on entry to POLL and increments on each non-stalled busy poll.
  - When the count reaches POLL_LIMIT, the FSM drops the latched byte, sets err_timeout=1 (sticky until reset) and returns to IDLE; no write is issued.
- Not defined: err_timeout is tied to 0, no counter logic exists, and POLL waits indefinitely.

Test Plan:
1. Reset, then req_valid=4'b0001 with req_data[7:0]=8'h0F, UART idle (rdata=0), no stall -> req_ready=4'b0001 for one cycle; status read at addr 28 next cycle; then bus_wen=1, addr 24, wdata=32'h0000000F; busy back to 0 at +3.
2. req_valid=4'b1111 held with bytes 8'hA0..A3 -> accept order 0,1,2,3,0; writes A0,A1,A2,A3,A0; last_grant follows the same order.
3. Status busy bit=1 for 5 polls, then 0 -> exactly 6 status reads, then one write; no write while busy.
4. bus_stall=1 for 3 cycles during WRITE -> bus_wen, addr and wdata stable for 4 cycles; exactly one write accepted.
5. nReset pulsed while in POLL -> all outputs 0 asynchronously; after release requester 0 wins over requester 3 when both are valid.
6. With UART_ARB_TIMEOUT_EN and POLL_LIMIT=4, busy bit stuck at 1 -> 4 non-stalled polls, err_timeout=1, return to IDLE, no write; without the macro the FSM stays in POLL and err_timeout stays 0.
